// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the processor register bank and its write-port arbiter.
package reg_write_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WIPE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/reg_write_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i wins.
module rr_priority_pick #(
   parameter  int NREQ  = 4,
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [IDX_W-1:0] winner_o,
   output logic             any_req_o
);

   int               sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt_o     = '0;
      winner_o  = '0;
      any_req_o = 1'b0;
      sum       = 0;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
         // Scan position wraps modulo NREQ without relying on a power-of-two width.
         sum = int'(rr_ptr_i) + k;
         if (sum >= NREQ) sum = sum - NREQ;
         idx = IDX_W'(sum);
         if (!any_req_o && req_i[idx]) begin
            any_req_o = 1'b1;
            winner_o  = idx;
         end
      end
      if (any_req_o) gnt_o[winner_o] = 1'b1;
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-bank write-port arbiter: round-robin grant of NREQ requesters into a
// registered write command, plus a sequencer that zeroes every bank address.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter  int NREQ     = 4,
   parameter  int ADDR_W   = REG_ADDR_W,
   parameter  int DATA_W   = REG_DATA_W,
   parameter  bit ZERO_REG = 1'b1,
   localparam int IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                     clk,
   input  logic                     clr_n,
   // Handshake: a requester holds req[i] with stable addr/data until it sees
   // gnt[i]=1 in some cycle; that cycle is the transfer, and req may change after.
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          gnt,
   input  logic                     wipe_req,
   output logic                     wipe_busy,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output arb_state_e               dbg_state,
   output logic [IDX_W-1:0]         dbg_rr_ptr
);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0] wipe_cnt_q, wipe_cnt_d;
   logic              busy_q, busy_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic [NREQ-1:0]   pick_gnt;
   logic [IDX_W-1:0]  pick_winner;
   logic              pick_any;

   logic [ADDR_W-1:0] addr_arr [NREQ];
   logic [DATA_W-1:0] data_arr [NREQ];
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
      assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
   end

   assign win_addr = addr_arr[pick_winner];
   assign win_data = data_arr[pick_winner];

   rr_priority_pick #(.NREQ(NREQ)) u_pick (
      .req_i     (req),
      .rr_ptr_i  (rr_ptr_q),
      .gnt_o     (pick_gnt),
      .winner_o  (pick_winner),
      .any_req_o (pick_any)
   );

   // A wipe request in IDLE pre-empts every requester in that same cycle.
   assign gnt = (clr_n && (state_q == ST_IDLE) && !wipe_req) ? pick_gnt : '0;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      wipe_cnt_d = wipe_cnt_q;
      busy_d     = 1'b0;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      case (state_q)
         ST_IDLE: begin
            if (wipe_req) begin
               state_d    = ST_WIPE;
               wipe_cnt_d = '0;
               busy_d     = 1'b1;
            end else if (pick_any) begin
               wr_en_d   = !(ZERO_REG && (win_addr == ADDR_W'(ZERO_ADDR)));
               wr_addr_d = win_addr;
               wr_data_d = win_data;
               rr_ptr_d  = (pick_winner == IDX_W'(NREQ - 1)) ? '0 : pick_winner + 1'b1;
            end
         end
         ST_WIPE: begin
            // Busy stays up into the first IDLE cycle, where the last wipe write is visible.
            busy_d    = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = wipe_cnt_q;
            wr_data_d = '0;
            if (wipe_cnt_q == '1) begin
               state_d    = ST_IDLE;
               wipe_cnt_d = '0;
            end else begin
               wipe_cnt_d = wipe_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         wipe_cnt_q <= '0;
         busy_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         wipe_cnt_q <= wipe_cnt_d;
         busy_q     <= busy_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign wipe_busy  = busy_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign dbg_state  = state_q;
   assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a write-command scoreboard.
module tb_reg_write_arbiter;
   import reg_write_arbiter_pkg::*;

   localparam int NREQ   = 4;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 2;

   logic                   clk = 1'b0;
   logic                   clr_n;
   logic [NREQ-1:0]        req;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        gnt;
   logic                   wipe_req;
   logic                   wipe_busy;
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [DATA_W-1:0]      wr_data;
   arb_state_e             dbg_state;
   logic [IDX_W-1:0]       dbg_rr_ptr;

   int n_checks = 0;
   int n_fail   = 0;
   int busy_cnt = 0;
   int wr_cnt   = 0;
   bit mon_en   = 1'b0;

   logic [ADDR_W+DATA_W-1:0] exp_q[$];

   reg_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(1'b1)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .req        (req),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .gnt        (gnt),
      .wipe_req   (wipe_req),
      .wipe_busy  (wipe_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .dbg_state  (dbg_state),
      .dbg_rr_ptr (dbg_rr_ptr)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         if (wipe_busy) busy_cnt++;
         if (wr_en) begin
            logic [ADDR_W+DATA_W-1:0] e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL wr_unexpected act=addr %0h data %0h exp=no write", wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(wr_addr), 64'(e[DATA_W +: ADDR_W]));
               chk("wr_data", 64'(wr_data), 64'(e[DATA_W-1:0]));
            end
         end
      end
   end

   // driver tasks
   task automatic set_src(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic step(input logic [NREQ-1:0] r, input logic w, input logic [NREQ-1:0] exp_gnt,
                       input string nm);
      req      = r;
      wipe_req = w;
      @(negedge clk);
      chk(nm, 64'(gnt), 64'(exp_gnt));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      clr_n = 1'b0;
      repeat (n) step(4'hF, 1'b0, 4'b0000, "rst_gnt");
      clr_n = 1'b1;
   endtask

   // Wipe entry plus the 32 WIPE cycles; retrig_a/retrig_b pulse wipe_req inside WIPE.
   task automatic run_wipe(input logic [NREQ-1:0] r, input int retrig_a, input int retrig_b);
      busy_cnt = 0;
      wr_cnt   = 0;
      step(r, 1'b1, 4'b0000, "wipe_entry_gnt");
      for (int a = 0; a < 32; a++) push_wr(ADDR_W'(a), '0);
      for (int k = 0; k < 32; k++)
         step(r, (k == retrig_a) || (k == retrig_b), 4'b0000, "wipe_gnt");
   endtask

   initial begin
      logic [NREQ-1:0] r;
      logic [NREQ-1:0] g;
      clr_n    = 1'b0;
      req      = '0;
      wipe_req = 1'b0;
      req_addr = '0;
      req_data = '0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // 1: reset, then a single request
      do_reset(2);
      @(negedge clk);
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_busy", 64'(wipe_busy), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      chk("rst_ptr", 64'(dbg_rr_ptr), 64'd0);
      @(posedge clk);
      #1;
      set_src(2, 5'd7, 32'hDEADBEEF);
      push_wr(5'd7, 32'hDEADBEEF);
      step(4'b0100, 1'b0, 4'b0100, "single_gnt");
      step(4'b0000, 1'b0, 4'b0000, "single_idle_gnt");
      chk("single_ptr", 64'(dbg_rr_ptr), 64'd3);

      // 2: fairness with all requesters, each dropping for one cycle after its grant
      do_reset(1);
      for (int i = 0; i < NREQ; i++) set_src(i, ADDR_W'(8 + i), 32'hA5A5_0000 | 32'(i));
      r = 4'hF;
      for (int k = 0; k < 8; k++) begin
         g = 4'b0001 << (k % 4);
         push_wr(ADDR_W'(8 + k % 4), 32'hA5A5_0000 | 32'(k % 4));
         step(r, 1'b0, g, "fair_gnt");
         r = 4'hF & ~g;
      end
      step(4'b0000, 1'b0, 4'b0000, "fair_idle_gnt");
      chk("fair_ptr", 64'(dbg_rr_ptr), 64'd0);

      // 3: address 0 is granted but not written; requester 2 wins next over 0
      set_src(1, 5'd0, 32'h55);
      set_src(2, 5'd12, 32'h0000_1234);
      set_src(0, 5'd9, 32'h0000_0909);
      step(4'b0010, 1'b0, 4'b0010, "zero_gnt");
      push_wr(5'd12, 32'h0000_1234);
      req = 4'b0101;
      @(negedge clk);
      chk("zero_next_gnt", 64'(gnt), 64'b0100);
      chk("zero_wr_en", 64'(wr_en), 64'd0);
      @(posedge clk);
      #1;
      step(4'b0000, 1'b0, 4'b0000, "zero_idle_gnt");
      chk("zero_ptr", 64'(dbg_rr_ptr), 64'd3);

      // 4: wipe beats simultaneous requests; pointer survives the wipe
      set_src(0, 5'd3, 32'h0000_0300);
      set_src(1, 5'd4, 32'h0000_0400);
      run_wipe(4'b0011, -1, -1);
      chk("wipe4_ptr_frozen", 64'(dbg_rr_ptr), 64'd3);
      push_wr(5'd3, 32'h0000_0300);
      step(4'b0011, 1'b0, 4'b0001, "wipe4_resume_gnt");
      step(4'b0000, 1'b0, 4'b0000, "wipe4_idle_gnt");
      chk("wipe4_busy_cycles", 64'(busy_cnt), 64'd33);
      chk("wipe4_writes", 64'(wr_cnt), 64'd33);
      chk("wipe4_q_empty", 64'(exp_q.size()), 64'd0);

      // 5: reset in the WIPE cycle with wipe_cnt = 10, then a fresh wipe
      do_reset(1);
      step(4'b0000, 1'b1, 4'b0000, "wipe5_entry_gnt");
      for (int a = 0; a < 10; a++) push_wr(ADDR_W'(a), '0);
      repeat (10) step(4'b0000, 1'b0, 4'b0000, "wipe5_gnt");
      chk("wipe5_state_mid", 64'(dbg_state), 64'(ST_WIPE));
      clr_n = 1'b0;
      step(4'b0000, 1'b0, 4'b0000, "wipe5_rst_gnt");
      clr_n = 1'b1;
      @(negedge clk);
      chk("wipe5_wr_en", 64'(wr_en), 64'd0);
      chk("wipe5_busy", 64'(wipe_busy), 64'd0);
      chk("wipe5_state", 64'(dbg_state), 64'(ST_IDLE));
      @(posedge clk);
      #1;
      chk("wipe5_q_empty", 64'(exp_q.size()), 64'd0);
      run_wipe(4'b0000, -1, -1);
      repeat (2) step(4'b0000, 1'b0, 4'b0000, "wipe5_idle_gnt");
      chk("wipe5_busy_cycles", 64'(busy_cnt), 64'd33);
      chk("wipe5_writes", 64'(wr_cnt), 64'd32);

      // 6: wipe_req pulses during WIPE are ignored
      run_wipe(4'b0000, 5, 20);
      repeat (3) step(4'b0000, 1'b0, 4'b0000, "wipe6_idle_gnt");
      chk("wipe6_busy_cycles", 64'(busy_cnt), 64'd33);
      chk("wipe6_writes", 64'(wr_cnt), 64'd32);
      chk("wipe6_state", 64'(dbg_state), 64'(ST_IDLE));

      // final report
      chk("final_q_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
